// File: rtl/msu_mcu_pkg.sv
// Shared constants for the MCU side of the MSU1 register block.
// Opcodes, FSM encodings and event-flag bit positions.
package msu_mcu_pkg;

  localparam logic [7:0] MSU_OP_SETPTR   = 8'hE0;
  localparam logic [7:0] MSU_OP_WRITE    = 8'hE1;
  localparam logic [7:0] MSU_OP_STATUS   = 8'hE2;
  localparam logic [7:0] MSU_OP_SNESPTR  = 8'hE3;
  localparam logic [7:0] MSU_OP_SNAPSHOT = 8'hEE;

  typedef logic [2:0] msu_state_t;
  localparam msu_state_t ST_IDLE   = 3'd0;
  localparam msu_state_t ST_ARG    = 3'd1;
  localparam msu_state_t ST_STREAM = 3'd2;
  localparam msu_state_t ST_READ   = 3'd3;
  localparam msu_state_t ST_PULSE  = 3'd4;

  localparam int EV_AUDIO = 0;
  localparam int EV_DATA  = 1;
  localparam int EV_CTRL  = 2;
  localparam int EV_VOL   = 3;
  localparam int EV_OVR   = 7;

  localparam int SNAP_BYTES = 9;

endpackage

// File: rtl/msu_mcu_bridge_if.sv
// Signal bundle between the MCU command deserializer / MSU register block and the bridge.
// slave = bridge view, master = environment view.
interface msu_mcu_bridge_if #(parameter int BUF_AW = 14);
  logic              cmd_frame;
  logic              cmd_strobe;
  logic [7:0]        cmd_data;
  logic [7:0]        resp_data;
  logic [BUF_AW-1:0] pgm_address;
  logic [7:0]        pgm_data;
  logic              pgm_we;
  logic [5:0]        status_reset_bits;
  logic [5:0]        status_set_bits;
  logic              status_reset_we;
  logic [BUF_AW-1:0] msu_address_ext;
  logic              msu_address_ext_write;
  logic [7:0]        status_in;
  logic [31:0]       addr_in;
  logic [15:0]       track_in;
  logic [7:0]        volume_in;
  logic              volume_latch_in;
  logic              msu_event;

  modport slave (
    input  cmd_frame, cmd_strobe, cmd_data,
    input  status_in, addr_in, track_in, volume_in, volume_latch_in,
    output resp_data, pgm_address, pgm_data, pgm_we,
    output status_reset_bits, status_set_bits, status_reset_we,
    output msu_address_ext, msu_address_ext_write, msu_event
  );

  modport master (
    output cmd_frame, cmd_strobe, cmd_data,
    output status_in, addr_in, track_in, volume_in, volume_latch_in,
    input  resp_data, pgm_address, pgm_data, pgm_we,
    input  status_reset_bits, status_set_bits, status_reset_we,
    input  msu_address_ext, msu_address_ext_write, msu_event
  );
endinterface

// File: rtl/msu_pulse_stretch.sv
// Turns a one-cycle start into a registered pulse exactly PULSE_LEN cycles wide,
// starting the cycle after start; a new start reloads the count.
module msu_pulse_stretch #(
  parameter int PULSE_LEN = 4
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic start,
  output logic pulse
);

  localparam int CW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(PULSE_LEN - 1);
      pulse <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/msu_mcu_bridge.sv
// MCU-facing end of the MSU1 register block: decodes MCU command frames into buffer
// writes, status/pointer pulses and a 9-byte snapshot readout, and tracks SNES-side events.
module msu_mcu_bridge
  import msu_mcu_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int BUF_AW    = 14
) (
  input logic              clkin,
  input logic              rst_n,
  msu_mcu_bridge_if.slave  bus
);

  msu_state_t                  state;
  logic [7:0]                  opcode;
  logic [7:0]                  arg_hi;
  logic [1:0]                  arg_cnt;
  logic [3:0]                  rd_idx;
  logic [3:0]                  rd_next;
  logic [SNAP_BYTES-1:0][7:0]  shadow;
  logic [3:0]                  ev_flags;
  logic [3:0]                  ev_prev;
  logic [3:0]                  ev_now;
  logic [3:0]                  ev_clr;
  logic                        ovr;
  logic                        ovr_set;
  logic                        flags_rd;
  logic                        strobe;
  logic                        st_kick;
  logic                        ad_kick;
  logic                        st_we;
  logic                        ad_we;
  logic [BUF_AW-1:0]           ptr_word;

  logic [7:0]        resp_q;
  logic [BUF_AW-1:0] pgm_addr_q;
  logic [7:0]        pgm_data_q;
  logic              pgm_we_q;
  logic [5:0]        rst_bits_q;
  logic [5:0]        set_bits_q;
  logic [BUF_AW-1:0] ext_addr_q;

  assign strobe   = bus.cmd_frame & bus.cmd_strobe;
  assign ptr_word = BUF_AW'({arg_hi, bus.cmd_data});
  assign rd_next  = rd_idx + 4'd1;

  // Bit order matches the flags byte: vol, ctrl, data, audio.
  assign ev_now   = {bus.volume_latch_in, bus.status_in[0], bus.status_in[5], bus.status_in[6]};
  assign flags_rd = (state == ST_READ) && strobe && (rd_idx == 4'd8);
  assign ev_clr   = flags_rd ? shadow[8][3:0] : 4'h0;
  assign ovr_set  = (state == ST_PULSE) && strobe;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      ev_prev  <= '0;
      ev_flags <= '0;
      ovr      <= 1'b0;
    end else begin
      ev_prev  <= ev_now;
      // A new edge in the same cycle as the read-clear survives.
      ev_flags <= (ev_flags & ~ev_clr) | (ev_now & ~ev_prev);
      ovr      <= (ovr & ~(flags_rd & shadow[8][EV_OVR])) | ovr_set;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      opcode     <= '0;
      arg_hi     <= '0;
      arg_cnt    <= '0;
      rd_idx     <= '0;
      shadow     <= '0;
      resp_q     <= '0;
      pgm_addr_q <= '0;
      pgm_data_q <= '0;
      pgm_we_q   <= 1'b1;
      rst_bits_q <= '0;
      set_bits_q <= '0;
      ext_addr_q <= '0;
      st_kick    <= 1'b0;
      ad_kick    <= 1'b0;
    end else begin
      st_kick <= 1'b0;
      ad_kick <= 1'b0;
      // Address advances only once the write strobe has been seen low.
      if (!pgm_we_q) begin
        pgm_we_q   <= 1'b1;
        pgm_addr_q <= pgm_addr_q + BUF_AW'(1);
      end
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            opcode  <= bus.cmd_data;
            arg_cnt <= '0;
            rd_idx  <= '0;
            resp_q  <= 8'h00;
            case (bus.cmd_data)
              MSU_OP_SETPTR, MSU_OP_STATUS, MSU_OP_SNESPTR: state <= ST_ARG;
              MSU_OP_WRITE: state <= ST_STREAM;
              MSU_OP_SNAPSHOT: begin
                state  <= ST_READ;
                shadow <= {ovr, 3'b000, ev_flags, bus.volume_in,
                           bus.track_in[7:0], bus.track_in[15:8],
                           bus.addr_in[7:0], bus.addr_in[15:8],
                           bus.addr_in[23:16], bus.addr_in[31:24], bus.status_in};
                resp_q <= bus.status_in;
              end
              default: begin
                state  <= ST_ARG;
                resp_q <= 8'hFF;
              end
            endcase
          end
        end
        ST_ARG: begin
          if (!bus.cmd_frame) begin
            state <= ST_IDLE;
          end else if (strobe && arg_cnt != 2'd2) begin
            arg_cnt <= arg_cnt + 2'd1;
            if (arg_cnt == 2'd0) begin
              arg_hi <= bus.cmd_data;
              if (opcode == MSU_OP_STATUS) rst_bits_q <= bus.cmd_data[5:0];
            end else begin
              case (opcode)
                MSU_OP_SETPTR: pgm_addr_q <= ptr_word;
                MSU_OP_STATUS: begin
                  set_bits_q <= bus.cmd_data[5:0];
                  st_kick    <= 1'b1;
                  state      <= ST_PULSE;
                end
                MSU_OP_SNESPTR: begin
                  ext_addr_q <= ptr_word;
                  ad_kick    <= 1'b1;
                  state      <= ST_PULSE;
                end
                default: ;
              endcase
            end
          end
        end
        ST_STREAM: begin
          if (!bus.cmd_frame) begin
            state <= ST_IDLE;
          end else if (strobe) begin
            pgm_data_q <= bus.cmd_data;
            pgm_we_q   <= 1'b0;
          end
        end
        ST_READ: begin
          if (!bus.cmd_frame) begin
            state <= ST_IDLE;
          end else if (strobe && rd_idx != 4'(SNAP_BYTES)) begin
            rd_idx <= rd_next;
            resp_q <= (rd_next < 4'(SNAP_BYTES)) ? shadow[rd_next] : 8'h00;
          end
        end
        ST_PULSE: begin
          // arg_cnt is already saturated, so a frame still open just ignores bytes.
          if (!st_kick && !ad_kick && !st_we && !ad_we)
            state <= bus.cmd_frame ? ST_ARG : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  msu_pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_status_pulse (
    .clkin (clkin),
    .rst_n (rst_n),
    .start (st_kick),
    .pulse (st_we)
  );

  msu_pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_addr_pulse (
    .clkin (clkin),
    .rst_n (rst_n),
    .start (ad_kick),
    .pulse (ad_we)
  );

  assign bus.resp_data             = resp_q;
  assign bus.pgm_address           = pgm_addr_q;
  assign bus.pgm_data              = pgm_data_q;
  assign bus.pgm_we                = pgm_we_q;
  assign bus.status_reset_bits     = rst_bits_q;
  assign bus.status_set_bits       = set_bits_q;
  assign bus.status_reset_we       = st_we;
  assign bus.msu_address_ext       = ext_addr_q;
  assign bus.msu_address_ext_write = ad_we;
  assign bus.msu_event             = |ev_flags;

endmodule

// File: tb/tb_msu_mcu_bridge.sv
// Directed bench for msu_mcu_bridge: hand-computed vectors, outputs sampled on the falling edge.
module tb_msu_mcu_bridge;

  logic clkin;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  msu_mcu_bridge_if #(.BUF_AW(14)) bus ();

  msu_mcu_bridge #(.PULSE_LEN(4), .BUF_AW(14)) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clkin);
    bus.cmd_data   = b;
    bus.cmd_strobe = 1'b1;
    @(negedge clkin);
    bus.cmd_strobe = 1'b0;
  endtask

  task automatic frame_on;
    @(negedge clkin);
    bus.cmd_frame = 1'b1;
  endtask

  task automatic frame_off;
    @(negedge clkin);
    bus.cmd_frame = 1'b0;
    @(negedge clkin);
  endtask

  // Checks the one-cycle write strobe and the post-write address step.
  task automatic stream_byte(input string tag, input logic [7:0] b,
                             input logic [13:0] at, input logic [13:0] nxt);
    send(b);
    chk({tag, "_we_low"}, 32'(bus.pgm_we), 32'h0);
    chk({tag, "_data"},   32'(bus.pgm_data), 32'(b));
    chk({tag, "_addr"},   32'(bus.pgm_address), 32'(at));
    idle(1);
    chk({tag, "_we_high"}, 32'(bus.pgm_we), 32'h1);
    chk({tag, "_addr_inc"}, 32'(bus.pgm_address), 32'(nxt));
  endtask

  task automatic snapshot(input string tag, input logic [7:0] exp_b [10]);
    frame_on();
    send(8'hEE);
    chk({tag, "_b0"}, 32'(bus.resp_data), 32'(exp_b[0]));
    for (int k = 1; k < 10; k++) begin
      send(8'h00);
      chk($sformatf("%s_b%0d", tag, k), 32'(bus.resp_data), 32'(exp_b[k]));
    end
    frame_off();
  endtask

  task automatic pulse_window(input string tag, input bit which);
    logic v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clkin);
      v = which ? bus.msu_address_ext_write : bus.status_reset_we;
      chk($sformatf("%s_high%0d", tag, i), 32'(v), 32'h1);
    end
    @(negedge clkin);
    v = which ? bus.msu_address_ext_write : bus.status_reset_we;
    chk({tag, "_low_after"}, 32'(v), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] snap1 [10];
    logic [7:0] snap2 [10];
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cmd_frame       = 1'b0;
    bus.cmd_strobe      = 1'b0;
    bus.cmd_data        = 8'h00;
    bus.status_in       = 8'h00;
    bus.addr_in         = 32'h0;
    bus.track_in        = 16'h0;
    bus.volume_in       = 8'h00;
    bus.volume_latch_in = 1'b0;
    idle(3);
    chk("rst_pgm_we",    32'(bus.pgm_we), 32'h1);
    chk("rst_st_we",     32'(bus.status_reset_we), 32'h0);
    chk("rst_ext_we",    32'(bus.msu_address_ext_write), 32'h0);
    chk("rst_event",     32'(bus.msu_event), 32'h0);
    chk("rst_pgm_addr",  32'(bus.pgm_address), 32'h0);
    chk("rst_resp",      32'(bus.resp_data), 32'h0);
    chk("rst_bits",      32'({bus.status_reset_bits, bus.status_set_bits}), 32'h0);
    chk("rst_ext_addr",  32'(bus.msu_address_ext), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Pointer set to the top of the buffer, then a two-byte stream that wraps.
    frame_on();
    send(8'hE0); send(8'h3F); send(8'hFF);
    frame_off();
    chk("setptr_addr", 32'(bus.pgm_address), 32'h3FFF);
    frame_on();
    send(8'hE1);
    stream_byte("wr_aa", 8'hAA, 14'h3FFF, 14'h0000);
    stream_byte("wr_bb", 8'hBB, 14'h0000, 14'h0001);
    frame_off();

    frame_on();
    send(8'h55);
    chk("unk_resp0", 32'(bus.resp_data), 32'hFF);
    send(8'h12);
    chk("unk_resp1", 32'(bus.resp_data), 32'hFF);
    chk("unk_no_ptr", 32'(bus.pgm_address), 32'h0001);
    frame_off();

    frame_on();
    send(8'hE2); send(8'h20); send(8'h01);
    chk("st_reset_bits", 32'(bus.status_reset_bits), 32'h20);
    chk("st_set_bits",   32'(bus.status_set_bits), 32'h01);
    chk("st_we_pre",     32'(bus.status_reset_we), 32'h0);
    pulse_window("st_we", 1'b0);
    chk("st_reset_held", 32'(bus.status_reset_bits), 32'h20);
    frame_off();

    frame_on();
    send(8'hE3); send(8'h12); send(8'h34);
    chk("ext_addr",   32'(bus.msu_address_ext), 32'h1234);
    chk("ext_we_pre", 32'(bus.msu_address_ext_write), 32'h0);
    pulse_window("ext_we", 1'b1);
    frame_off();

    bus.addr_in   = 32'h01020304;
    bus.track_in  = 16'hBEEF;
    bus.volume_in = 8'h55;
    @(negedge clkin);
    bus.status_in = 8'h40;
    idle(1);
    chk("event_audio", 32'(bus.msu_event), 32'h1);
    snap1 = '{8'h40, 8'h01, 8'h02, 8'h03, 8'h04, 8'hBE, 8'hEF, 8'h55, 8'h01, 8'h00};
    snapshot("snap1", snap1);
    chk("event_cleared", 32'(bus.msu_event), 32'h0);

    // A byte landing mid-pulse is dropped and flagged as overrun.
    frame_on();
    send(8'hE2); send(8'h0F); send(8'h30);
    send(8'h3C);
    chk("ovr_reset_bits", 32'(bus.status_reset_bits), 32'h0F);
    chk("ovr_set_bits",   32'(bus.status_set_bits), 32'h30);
    idle(8);
    frame_off();
    bus.addr_in = 32'hA1B2C3D4;
    snap2 = '{8'h40, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hBE, 8'hEF, 8'h55, 8'h80, 8'h00};
    snapshot("snap2", snap2);
    chk("ovr_no_event", 32'(bus.msu_event), 32'h0);

    bus.status_in = 8'h00;
    frame_on();
    send(8'hE0); send(8'h00); send(8'h10);
    frame_off();
    frame_on();
    send(8'hE1);
    stream_byte("pre_rst", 8'h11, 14'h0010, 14'h0011);
    send(8'h22);
    chk("mid_rst_we_low", 32'(bus.pgm_we), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_we",   32'(bus.pgm_we), 32'h1);
    chk("async_rst_addr", 32'(bus.pgm_address), 32'h0);
    chk("async_rst_data", 32'(bus.pgm_data), 32'h0);
    bus.cmd_frame = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    frame_on();
    send(8'hE1);
    stream_byte("post_rst", 8'h33, 14'h0000, 14'h0001);
    frame_off();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/msu_mcu_bridge.md
Name: msu_mcu_bridge

Overview:
- MCU-facing end of the MSU1 register block; the SNES-facing end is a separate block, referred to below as "the MSU register block".
- Consumes the deserialized MCU command byte stream (one byte per cmd_strobe, framed by cmd_frame).
- Writes the MSU data buffer, seeds the SNES read pointer, and sets/clears the MSU status bits.
- Returns a snapshot of MSU status, address, track and volume, and raises an event line when the SNES starts a data seek, an audio track, a control write or a volume change.

Parameters:
- PULSE_LEN, 4, cycles that status_reset_we / msu_address_ext_write are held high. Must be >= 3 so the MSU register block's synchronizers catch the edge.
- BUF_AW, 14, MSU data buffer address width.

Ports:
- clkin  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_frame  in  1  high while an MCU transaction is active; falling edge ends the command
- cmd_strobe  in  1  one-cycle pulse: cmd_data valid
- cmd_data  in  8  command/payload byte
- resp_data  out  8  response byte for the next cmd_strobe
- pgm_address  out  BUF_AW  data buffer write address
- pgm_data  out  8  data buffer write data
- pgm_we  out  1  active-low buffer write strobe
- status_reset_bits  out  6  bits to clear in MSU status
- status_set_bits  out  6  bits to set in MSU status
- status_reset_we  out  1  status update pulse
- msu_address_ext  out  BUF_AW  new SNES read pointer
- msu_address_ext_write  out  1  pointer load pulse
- status_in  in  8  MSU status_out
- addr_in  in  32  MSU addr_out
- track_in  in  16  MSU track_out
- volume_in  in  8  MSU volume_out
- volume_latch_in  in  1  MSU volume_latch_out
- msu_event  out  1  level; pending SNES-side request

Behaviour:
- Reset values:
  - pgm_we=1; status_reset_we=0; msu_address_ext_write=0; msu_event=0.
  - pgm_address, pgm_data, msu_address_ext, resp_data, status bits outputs all 0.
  - FSM in IDLE.
- FSM states:
  - IDLE: first strobe in a frame latches the opcode.
  - ARG: counts payload bytes.
  - STREAM: buffer writes.
  - READ: snapshot readout.
  - PULSE: counter running.
  - cmd_frame low forces IDLE from any state, except that a running PULSE completes.
- Opcode 0xE0, set buffer pointer:
  - Next two bytes are hi, lo; pgm_address <= {hi[5:0], lo} after the second byte.
  - Further bytes are ignored.
- Opcode 0xE1, write stream:
  - Each byte: pgm_data <= byte, pgm_we low for exactly one cycle in the cycle after the strobe.
  - pgm_address increments on the cycle after the write and wraps 0x3FFF -> 0x0000.
  - Unlimited length within the frame.
- Opcode 0xE2, status update:
  - Byte1 gives reset_bits[5:0]; byte2 gives set_bits[5:0].
  - After byte2, outputs are stable and then status_reset_we is high for PULSE_LEN cycles; outputs are held through the pulse.
- Opcode 0xE3, SNES pointer:
  - Bytes hi, lo set msu_address_ext, then msu_address_ext_write is high for PULSE_LEN cycles.
- Opcode 0xEE, snapshot:
  - At the opcode strobe, latch all inputs into a 9-byte shadow: status, addr[31:24], [23:16], [15:8], [7:0], track[15:8], [7:0], volume, event flags.
  - resp_data presents shadow byte n on strobe n+1 (first payload strobe returns status).
  - After the 9th byte, resp_data=0x00.
  - Reading the event-flags byte clears the pending bits captured in it.
- Unknown opcode: remaining bytes are ignored and resp_data=0xFF.
- Event flags (bit3 vol, bit2 ctrl, bit1 data, bit0 audio):
  - Set on rising edges of volume_latch_in, status_in[0], status_in[5] and status_in[6].
  - msu_event = OR of flags.
  - A set in the same cycle as a clear wins, so no event is lost.
- Strobe arriving while in PULSE:
  - The byte is dropped.
  - An internal overrun flag is set and returned as bit7 of the event-flags byte.

Decomposition:
- Package msu_mcu_pkg holds:
  - opcode constants MSU_OP_SETPTR, MSU_OP_WRITE, MSU_OP_STATUS, MSU_OP_SNESPTR, MSU_OP_SNAPSHOT;
  - the FSM state enum;
  - event bit indices.
- One sub-module, msu_pulse_stretch: parameterized PULSE_LEN counter, used twice.

Test Plan:
- E0 3F FF, E1 AA BB -> 0xAA written at 0x3FFF, 0xBB at 0x0000; each pgm_we low for 1 cycle.
- E2 20 01 -> status_reset_bits=0x20 and status_set_bits=0x01 stable, then status_reset_we high 4 cycles.
- E3 12 34 -> msu_address_ext=0x1234, then msu_address_ext_write high 4 cycles.
- status_in bit6 rises -> msu_event=1. Then EE with addr_in=0x01020304 and track_in=0xBEEF returns:
  - status, 01 02 03 04 EF BE... ordered as spec: 01 02 03 04, BE EF;
  - volume, then flags 0x01;
  - msu_event=0 afterwards.
- rst_n low mid-E1 stream -> pgm_we=1 immediately (asynchronous), FSM IDLE; next frame E1 writes at address 0.
- Strobe during E2 pulse -> byte dropped, overrun bit7 reported in the next snapshot.
